io_stream_port: RTL and testbench

//  I/O-mapped streaming peripheral downstream of the core IO port: decodes io_addr/io_wr_strobe/io_rd_strobe.

---
 rtl/io_stream_port.sv | 164 ++++++++++++++++
 tb/tb_io_stream_port.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/io_stream_port.sv
// IO-mapped stream peripheral: core writes feed a TX FIFO drained by a valid/ready stream,
// stream words fill an RX FIFO that the core pops by reading; a status register sits alongside.

module io_stream_fifo #(
   parameter int unsigned W  = 16,
   parameter int unsigned AW = 3
) (
   input  logic         clk_i,
   input  logic         reset_n_i,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] wdata_i,
   output logic [W-1:0] head_o,
   output logic         full_o,
   output logic         empty_o
);
   localparam int unsigned DEPTH = 1 << AW;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [AW:0]   count_q, count_d;

   // Callers only push when not full and pop when not empty (pre-edge state).
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (push_i) wptr_d = wptr_q + AW'(1);
      if (pop_i)  rptr_d = rptr_q + AW'(1);
      case ({push_i, pop_i})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         mem_q   <= '{default: '0};
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (push_i) mem_q[wptr_q] <= wdata_i;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   assign head_o  = mem_q[rptr_q];
   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
endmodule

module io_stream_port #(
   parameter int unsigned nat_w      = 16,
   parameter int unsigned DEPTH_LOG2 = 3,
   parameter logic [7:0]  BASE_ADDR  = 8'h40
) (
   input  logic             clk_i,
   input  logic             reset_n_i,
   input  logic [7:0]       io_addr_i,
   input  logic             io_wr_strobe_i,
   input  logic             io_rd_strobe_i,
   input  logic [nat_w-1:0] io_data_i,
   output logic [nat_w-1:0] io_data_o,
   output logic             tx_valid_o,
   output logic [nat_w-1:0] tx_data_o,
   input  logic             tx_ready_i,
   input  logic             rx_valid_i,
   input  logic [nat_w-1:0] rx_data_i,
   output logic             rx_ready_o
);
   localparam logic [7:0] STAT_ADDR = BASE_ADDR + 8'd1;

   typedef struct packed {
      logic rx_udf;
      logic tx_ovf;
      logic rx_empty;
      logic rx_full;
      logic tx_empty;
      logic tx_full;
   } status_t;

   logic             data_sel, stat_sel;
   logic             tx_full, tx_empty, rx_full, rx_empty;
   logic             tx_push, tx_pop, rx_push, rx_pop;
   logic             tx_wr, rx_rd, stat_wr;
   logic [nat_w-1:0] rx_head;
   logic             tx_ovf_q, tx_ovf_d;
   logic             rx_udf_q, rx_udf_d;
   status_t          status;

   assign data_sel = (io_addr_i == BASE_ADDR);
   assign stat_sel = (io_addr_i == STAT_ADDR);
   assign tx_wr    = io_wr_strobe_i & data_sel;
   assign rx_rd    = io_rd_strobe_i & data_sel;
   assign stat_wr  = io_wr_strobe_i & stat_sel;

   assign tx_push    = tx_wr & ~tx_full;
   assign tx_valid_o = ~tx_empty;
   assign tx_pop     = tx_valid_o & tx_ready_i;
   assign rx_ready_o = ~rx_full;
   assign rx_push    = rx_valid_i & rx_ready_o;
   assign rx_pop     = rx_rd & ~rx_empty;

   io_stream_fifo #(.W(nat_w), .AW(DEPTH_LOG2)) u_tx_fifo (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .push_i    (tx_push),
      .pop_i     (tx_pop),
      .wdata_i   (io_data_i),
      .head_o    (tx_data_o),
      .full_o    (tx_full),
      .empty_o   (tx_empty)
   );

   io_stream_fifo #(.W(nat_w), .AW(DEPTH_LOG2)) u_rx_fifo (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .push_i    (rx_push),
      .pop_i     (rx_pop),
      .wdata_i   (rx_data_i),
      .head_o    (rx_head),
      .full_o    (rx_full),
      .empty_o   (rx_empty)
   );

   // Set terms are OR-ed last so a new event beats a same-edge clear.
   always_comb begin
      tx_ovf_d = (tx_ovf_q & ~(stat_wr & io_data_i[4])) | (tx_wr & tx_full);
      rx_udf_d = (rx_udf_q & ~(stat_wr & io_data_i[5])) | (rx_rd & rx_empty);
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         tx_ovf_q <= 1'b0;
         rx_udf_q <= 1'b0;
      end else begin
         tx_ovf_q <= tx_ovf_d;
         rx_udf_q <= rx_udf_d;
      end
   end

   always_comb begin
      status.rx_udf   = rx_udf_q;
      status.tx_ovf   = tx_ovf_q;
      status.rx_empty = rx_empty;
      status.rx_full  = rx_full;
      status.tx_empty = tx_empty;
      status.tx_full  = tx_full;
   end

   // Unmatched addresses drive 0 so several peripherals can be OR-ed onto one bus.
   always_comb begin
      io_data_o = '0;
      if (reset_n_i) begin
         if (data_sel)      io_data_o = rx_empty ? '0 : rx_head;
         else if (stat_sel) io_data_o = nat_w'(status);
      end
   end
endmodule

// File: tb/tb_io_stream_port.sv
// Scoreboarded bench for io_stream_port: a queue-based model predicts stream words and read data.

module tb_io_stream_port;
   localparam logic [7:0] BASE = 8'h40;
   localparam logic [7:0] STAT = 8'h41;

   logic        clk;
   logic        reset_n;
   logic [7:0]  io_addr;
   logic        io_wr, io_rd;
   logic [15:0] io_wdata, io_rdata;
   logic        tx_valid, tx_ready, rx_valid, rx_ready;
   logic [15:0] tx_data, rx_data;

   io_stream_port #(.nat_w(16), .DEPTH_LOG2(3), .BASE_ADDR(8'h40)) dut (
      .clk_i          (clk),
      .reset_n_i      (reset_n),
      .io_addr_i      (io_addr),
      .io_wr_strobe_i (io_wr),
      .io_rd_strobe_i (io_rd),
      .io_data_i      (io_wdata),
      .io_data_o      (io_rdata),
      .tx_valid_o     (tx_valid),
      .tx_data_o      (tx_data),
      .tx_ready_i     (tx_ready),
      .rx_valid_i     (rx_valid),
      .rx_data_i      (rx_data),
      .rx_ready_o     (rx_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errs = 0;
   int checks = 0;

   // Model state: plain queues of words plus the two sticky flags.
   logic [15:0] m_tx[$];
   logic [15:0] m_rx[$];
   bit          m_ovf, m_udf;
   // Scoreboard queues consumed by the monitor.
   logic [15:0] exp_tx[$];
   logic [15:0] exp_rd[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] m_status();
      return {10'b0, m_udf, m_ovf, m_rx.size() == 0, m_rx.size() == 8,
              m_tx.size() == 0, m_tx.size() == 8};
   endfunction

   // Monitor: compares every stream handshake and every read strobe against the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         #4;
         if (reset_n && tx_valid && tx_ready) begin
            if (exp_tx.size() == 0) begin
               checks++; errs++;
               $display("FAIL tx_word: got %h expected none", tx_data);
            end else chk("tx_word", tx_data, exp_tx.pop_front());
         end
         if (reset_n && io_rd) begin
            if (exp_rd.size() == 0) begin
               checks++; errs++;
               $display("FAIL rd_data: got %h expected none", io_rdata);
            end else chk("rd_data", io_rdata, exp_rd.pop_front());
         end
      end
   end

   task automatic step(input bit wr, input bit rd, input logic [7:0] addr, input logic [15:0] wd,
                       input bit trdy, input bit rvld, input logic [15:0] rdat);
      bit tx_wr, tx_ok, tx_pop, rx_rd, rx_pop, rx_push, clr;
      @(negedge clk);
      io_wr = wr; io_rd = rd; io_addr = addr; io_wdata = wd;
      tx_ready = trdy; rx_valid = rvld; rx_data = rdat;
      tx_wr   = wr && addr == BASE;
      tx_ok   = tx_wr && m_tx.size() < 8;
      tx_pop  = m_tx.size() > 0 && trdy;
      rx_rd   = rd && addr == BASE;
      rx_pop  = rx_rd && m_rx.size() > 0;
      rx_push = rvld && m_rx.size() < 8;
      clr     = wr && addr == STAT;
      if (rd) begin
         if (addr == BASE)      exp_rd.push_back(m_rx.size() > 0 ? m_rx[0] : 16'h0);
         else if (addr == STAT) exp_rd.push_back(m_status());
         else                   exp_rd.push_back(16'h0);
      end
      if (tx_ok) exp_tx.push_back(wd);
      #4;
      chk("tx_valid", tx_valid, m_tx.size() > 0);
      chk("rx_ready", rx_ready, m_rx.size() < 8);
      if (m_tx.size() > 0) chk("tx_head", tx_data, m_tx[0]);
      if (clr && wd[4]) m_ovf = 0;
      if (clr && wd[5]) m_udf = 0;
      if (tx_wr && !tx_ok) m_ovf = 1;
      if (rx_rd && !rx_pop) m_udf = 1;
      if (tx_pop)  void'(m_tx.pop_front());
      if (tx_ok)   m_tx.push_back(wd);
      if (rx_pop)  void'(m_rx.pop_front());
      if (rx_push) m_rx.push_back(rdat);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 8'h00, 16'h0, 0, 0, 16'h0);
   endtask

   // Reset asserted between edges; outputs must fall asynchronously.
   task automatic do_reset();
      @(negedge clk);
      io_wr = 0; io_rd = 0; io_addr = STAT; tx_ready = 0; rx_valid = 0;
      #2;
      reset_n = 1'b0;
      #1;
      chk("rst_tx_valid", tx_valid, 1'b0);
      chk("rst_tx_data", tx_data, 16'h0);
      chk("rst_rx_ready", rx_ready, 1'b1);
      chk("rst_io_data", io_rdata, 16'h0);
      m_tx.delete(); m_rx.delete(); exp_tx.delete(); exp_rd.delete();
      m_ovf = 0; m_udf = 0;
      @(negedge clk);
      #2;
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n = 1'b0;
      io_wr = 0; io_rd = 0; io_addr = 8'h00; io_wdata = 16'h0;
      tx_ready = 0; rx_valid = 0; rx_data = 16'h0;
      #3;
      chk("por_tx_valid", tx_valid, 1'b0);
      chk("por_rx_ready", rx_ready, 1'b1);
      #10;
      reset_n = 1'b1;

      // 1) single write appears one cycle later
      step(0, 1, STAT, 16'h0, 0, 0, 16'h0);
      step(1, 0, BASE, 16'h1234, 0, 0, 16'h0);
      step(0, 1, STAT, 16'h0, 0, 0, 16'h0);
      chk("t1_tx_data", tx_data, 16'h1234);

      // 2) overflow on the ninth write, then in-order drain
      do_reset();
      for (int i = 1; i <= 9; i++) step(1, 0, BASE, 16'(i), 0, 0, 16'h0);
      step(0, 1, STAT, 16'h0, 0, 0, 16'h0);
      for (int i = 0; i < 8; i++) step(0, 0, 8'h00, 16'h0, 1, 0, 16'h0);
      step(0, 1, STAT, 16'h0, 1, 0, 16'h0);

      // 3) RX reads in order, then underflow
      do_reset();
      step(0, 0, 8'h00, 16'h0, 0, 1, 16'hBEEF);
      step(0, 0, 8'h00, 16'h0, 0, 1, 16'hCAFE);
      step(0, 1, BASE, 16'h0, 0, 0, 16'h0);
      step(0, 1, BASE, 16'h0, 0, 0, 16'h0);
      step(0, 1, STAT, 16'h0, 0, 0, 16'h0);
      step(0, 1, BASE, 16'h0, 0, 0, 16'h0);
      step(0, 1, STAT, 16'h0, 0, 0, 16'h0);

      // 4) sticky clear, foreign addresses have no effect
      step(1, 0, 8'h40, 16'hAAAA, 0, 0, 16'h0);
      for (int i = 0; i < 9; i++) step(1, 0, BASE, 16'h1000 + 16'(i), 0, 0, 16'h0);
      step(0, 1, STAT, 16'h0, 0, 0, 16'h0);
      step(1, 0, STAT, 16'h0030, 0, 0, 16'h0);
      step(0, 1, STAT, 16'h0, 0, 0, 16'h0);
      step(1, 1, 8'h55, 16'hFFFF, 0, 0, 16'h0);
      step(0, 1, STAT, 16'h0, 0, 0, 16'h0);

      // 5) RX full with a same-edge read and offered word
      do_reset();
      for (int i = 0; i < 8; i++) step(0, 0, 8'h00, 16'h0, 0, 1, 16'h5000 + 16'(i));
      step(0, 1, STAT, 16'h0, 0, 0, 16'h0);
      step(0, 1, BASE, 16'h0, 0, 1, 16'hDEAD);
      step(0, 1, STAT, 16'h0, 0, 0, 16'h0);
      step(0, 1, BASE, 16'h0, 0, 0, 16'h0);

      // 6) reset with five TX words queued
      do_reset();
      for (int i = 0; i < 5; i++) step(1, 0, BASE, 16'h7000 + 16'(i), 0, 0, 16'h0);
      do_reset();
      step(0, 1, STAT, 16'h0, 0, 0, 16'h0);
      #4;
      chk("t6_status", io_rdata, 16'h000A);

      // randomized traffic
      for (int n = 0; n < 1500; n++) begin
         logic [7:0]  a;
         logic [15:0] d;
         int sel;
         sel = int'($urandom_range(0, 9));
         a = (sel < 5) ? BASE : (sel < 8) ? STAT : (sel == 8) ? 8'h55 : 8'($urandom);
         d = 16'($urandom);
         step($urandom_range(0, 9) < 4, $urandom_range(0, 9) < 4, a, d,
              $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 4, 16'($urandom));
         if (n == 700) do_reset();
      end
      idle(2);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
